rcv_fifo: RTL and testbench

Receive-side byte FIFO that sits directly downstream of the UART receiver block. It drains completed bytes from the receiver's data buffer via the `data_ready`/`data_read` handshake and tags each byte with the overrun status present at capture. It presents bytes to the consumer first-word-fall-through and counts framing-error events. When full it applies backpressure by leaving bytes in the receiver buffer.

---
 rtl/rcv_fifo.sv | 99 +++++++++
 tb/tb_rcv_fifo.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcv_fifo.sv
// Receive-side byte FIFO fed from the UART receiver buffer.
// Bytes are captured with their overrun tag, read first-word-fall-through, and framing-error edges are counted.
module rcv_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic [7:0]    rx_data,
  input  logic          data_ready,
  input  logic          overrun_error,
  input  logic          framing_error,
  output logic          data_read,
  input  logic          r_enable,
  output logic [7:0]    r_data,
  output logic          r_oerr,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  input  logic          clear_errors,
  output logic [7:0]    ferr_count
);

  typedef enum logic {IDLE, ACK} state_t;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  state_t        state, state_next;
  logic          capture, pop, ferr_edge, ferr_prev;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [8:0]    mem [DEPTH];

  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign pop       = r_enable && !empty;
  assign ferr_edge = framing_error && !ferr_prev;
  assign r_data    = empty ? 8'h00 : mem[rd_ptr][7:0];
  assign r_oerr    = empty ? 1'b0  : mem[rd_ptr][8];

  // ACK exists only to skip the cycle where data_ready still reflects the acknowledged byte
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (data_ready && !full) begin
          capture    = 1'b1;
          state_next = ACK;
        end
      end
      ACK: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= IDLE;
      data_read <= 1'b0;
    end else begin
      state     <= state_next;
      data_read <= capture;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= {overrun_error, rx_data};
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (capture) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({capture, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A clear coinciding with a new edge keeps that edge rather than losing it
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      ferr_prev  <= 1'b0;
      ferr_count <= 8'd0;
    end else begin
      ferr_prev <= framing_error;
      if (clear_errors)
        ferr_count <= ferr_edge ? 8'd1 : 8'd0;
      else if (ferr_edge && ferr_count != 8'hFF)
        ferr_count <= ferr_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_rcv_fifo.sv
// Bench for rcv_fifo: constant vector table, directed corner sequences and random traffic,
// all cross-checked every cycle against a queue-based reference model.
module tb_rcv_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       data_ready = 1'b0;
  logic       overrun_error = 1'b0;
  logic       framing_error = 1'b0;
  logic       data_read;
  logic       r_enable = 1'b0;
  logic [7:0] r_data;
  logic       r_oerr;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       clear_errors = 1'b0;
  logic [7:0] ferr_count;

  int checks = 0;
  int errors = 0;

  logic [8:0] mq[$];
  bit         m_read = 1'b0;
  bit         m_prev = 1'b0;
  int         m_ferr = 0;

  typedef struct {
    int n_rst, data_ready, rx_data, overrun_error, framing_error, r_enable, clear_errors;
    int exp_count, exp_data, exp_oerr, exp_read, exp_ferr;
  } vec_t;

  vec_t vecs[15];

  rcv_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .data_ready(data_ready),
    .overrun_error(overrun_error), .framing_error(framing_error), .data_read(data_read),
    .r_enable(r_enable), .r_data(r_data), .r_oerr(r_oerr), .empty(empty), .full(full),
    .count(count), .clear_errors(clear_errors), .ferr_count(ferr_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference behaviour from the inputs currently driven, evaluated for the coming edge
  task automatic modelStep();
    bit cap, pp, edge_seen;
    if (!n_rst) begin
      mq.delete();
      m_read = 1'b0;
      m_prev = 1'b0;
      m_ferr = 0;
    end else begin
      cap = !m_read && data_ready && (mq.size() < DEPTH);
      pp  = r_enable && (mq.size() > 0);
      if (pp)  void'(mq.pop_front());
      if (cap) mq.push_back({overrun_error, rx_data});
      m_read = cap;
      edge_seen = framing_error && !m_prev;
      m_prev = framing_error;
      if (clear_errors)   m_ferr = edge_seen ? 1 : 0;
      else if (edge_seen) m_ferr = (m_ferr < 255) ? m_ferr + 1 : 255;
    end
  endtask

  task automatic compareModel();
    int n;
    n = mq.size();
    checkOutput("model count", 32'(count), 32'(n));
    checkOutput("model empty", 32'(empty), 32'(n == 0));
    checkOutput("model full", 32'(full), 32'(n == DEPTH));
    checkOutput("model r_data", 32'(r_data), (n > 0) ? 32'(mq[0][7:0]) : 32'd0);
    checkOutput("model r_oerr", 32'(r_oerr), (n > 0) ? 32'(mq[0][8]) : 32'd0);
    checkOutput("model data_read", 32'(data_read), 32'(m_read));
    checkOutput("model ferr_count", 32'(ferr_count), 32'(m_ferr));
  endtask

  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
    compareModel();
  endtask

  task automatic setIn(input bit nr, input bit dr, input logic [7:0] rx, input bit oe,
                       input bit fe, input bit re, input bit ce);
    n_rst = nr; data_ready = dr; rx_data = rx; overrun_error = oe;
    framing_error = fe; r_enable = re; clear_errors = ce;
  endtask

  task automatic doReset();
    setIn(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus();
    n_rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit seen;
    int phase;

    //         nrst dr  rx    oe fe re ce   cnt data  oerr rd ferr
    vecs[0]  = '{0, 0, 'h00, 0, 0, 0, 0,   0, 'h00, 0, 0, 0};
    vecs[1]  = '{1, 1, 'hA5, 0, 0, 0, 0,   1, 'hA5, 0, 1, 0};
    vecs[2]  = '{1, 1, 'hA5, 0, 0, 0, 0,   1, 'hA5, 0, 0, 0};
    vecs[3]  = '{1, 0, 'h00, 0, 0, 0, 0,   1, 'hA5, 0, 0, 0};
    vecs[4]  = '{1, 1, 'h7E, 1, 0, 0, 0,   2, 'hA5, 0, 1, 0};
    vecs[5]  = '{1, 0, 'h00, 0, 0, 1, 0,   1, 'h7E, 1, 0, 0};
    vecs[6]  = '{1, 0, 'h00, 0, 0, 1, 0,   0, 'h00, 0, 0, 0};
    vecs[7]  = '{1, 0, 'h00, 0, 0, 1, 0,   0, 'h00, 0, 0, 0};
    vecs[8]  = '{1, 1, 'h3C, 0, 0, 1, 0,   1, 'h3C, 0, 1, 0};
    vecs[9]  = '{1, 0, 'h00, 0, 0, 1, 0,   0, 'h00, 0, 0, 0};
    vecs[10] = '{1, 0, 'h00, 0, 1, 0, 0,   0, 'h00, 0, 0, 1};
    vecs[11] = '{1, 0, 'h00, 0, 1, 0, 0,   0, 'h00, 0, 0, 1};
    vecs[12] = '{1, 0, 'h00, 0, 0, 0, 0,   0, 'h00, 0, 0, 1};
    vecs[13] = '{1, 0, 'h00, 0, 1, 0, 1,   0, 'h00, 0, 0, 1};
    vecs[14] = '{1, 0, 'h00, 0, 0, 0, 1,   0, 'h00, 0, 0, 0};

    for (int i = 0; i < 15; i++) begin
      setIn(vecs[i].n_rst != 0, vecs[i].data_ready != 0, 8'(vecs[i].rx_data),
            vecs[i].overrun_error != 0, vecs[i].framing_error != 0,
            vecs[i].r_enable != 0, vecs[i].clear_errors != 0);
      applyStimulus();
      checkOutput($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
      checkOutput($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].exp_count == 0));
      checkOutput($sformatf("vec%0d r_data", i), 32'(r_data), 32'(vecs[i].exp_data));
      checkOutput($sformatf("vec%0d r_oerr", i), 32'(r_oerr), 32'(vecs[i].exp_oerr));
      checkOutput($sformatf("vec%0d data_read", i), 32'(data_read), 32'(vecs[i].exp_read));
      checkOutput($sformatf("vec%0d ferr_count", i), 32'(ferr_count), 32'(vecs[i].exp_ferr));
    end

    // Fill to full, then show backpressure and in-order drain
    doReset();
    for (int i = 1; i <= 8; i++) begin
      data_ready = 1'b1; rx_data = 8'(i);
      applyStimulus();
      checkOutput("fill data_read", 32'(data_read), 32'd1);
      data_ready = 1'b0;
      applyStimulus();
    end
    checkOutput("fill full", 32'(full), 32'd1);
    checkOutput("fill count", 32'(count), 32'd8);
    data_ready = 1'b1; rx_data = 8'h09;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("full no data_read", 32'(data_read), 32'd0);
    end
    r_enable = 1'b1;
    applyStimulus();
    checkOutput("pop while full no capture", 32'(data_read), 32'd0);
    checkOutput("pop while full count", 32'(count), 32'd7);
    r_enable = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus();
      if (data_read) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("late capture of 09", 32'(seen), 32'd1);
    data_ready = 1'b0;
    applyStimulus();
    for (int v = 2; v <= 9; v++) begin
      checkOutput("drain order", 32'(r_data), 32'(v));
      r_enable = 1'b1;
      applyStimulus();
    end
    r_enable = 1'b0;
    checkOutput("drained empty", 32'(empty), 32'd1);

    // Simultaneous capture and pop at three entries, then mixed traffic across the wrap
    doReset();
    for (int i = 0; i < 3; i++) begin
      data_ready = 1'b1; rx_data = 8'(8'h11 + i);
      applyStimulus();
      data_ready = 1'b0;
      applyStimulus();
    end
    data_ready = 1'b1; rx_data = 8'h14; r_enable = 1'b1;
    applyStimulus();
    checkOutput("simultaneous count", 32'(count), 32'd3);
    checkOutput("simultaneous head", 32'(r_data), 32'h12);
    for (int i = 0; i < 20; i++) begin
      data_ready = 1'($urandom_range(0, 1));
      rx_data    = 8'($urandom);
      r_enable   = 1'($urandom_range(0, 1));
      applyStimulus();
    end
    data_ready = 1'b0; r_enable = 1'b0;

    // Framing counter: pulses, long hold, saturation, clear with edge
    doReset();
    framing_error = 1'b1; applyStimulus();
    framing_error = 1'b0; applyStimulus();
    framing_error = 1'b1; repeat (5) applyStimulus();
    framing_error = 1'b0; applyStimulus();
    framing_error = 1'b1; applyStimulus();
    framing_error = 1'b0; applyStimulus();
    checkOutput("ferr three edges", 32'(ferr_count), 32'd3);
    for (int i = 0; i < 260; i++) begin
      framing_error = 1'b1; applyStimulus();
      framing_error = 1'b0; applyStimulus();
    end
    checkOutput("ferr saturate", 32'(ferr_count), 32'd255);
    framing_error = 1'b1; clear_errors = 1'b1;
    applyStimulus();
    checkOutput("ferr clear with edge", 32'(ferr_count), 32'd1);
    framing_error = 1'b0; clear_errors = 1'b0;
    applyStimulus();

    // Overrun tag, then reset while in the acknowledge cycle
    doReset();
    data_ready = 1'b1; rx_data = 8'h7E; overrun_error = 1'b1;
    applyStimulus();
    checkOutput("oerr ack", 32'(data_read), 32'd1);
    checkOutput("oerr tag", 32'(r_oerr), 32'd1);
    checkOutput("oerr data", 32'(r_data), 32'h7E);
    n_rst = 1'b0;
    applyStimulus();
    checkOutput("reset in ack data_read", 32'(data_read), 32'd0);
    checkOutput("reset in ack count", 32'(count), 32'd0);
    checkOutput("reset in ack r_data", 32'(r_data), 32'd0);
    checkOutput("reset in ack r_oerr", 32'(r_oerr), 32'd0);
    checkOutput("reset in ack empty", 32'(empty), 32'd1);
    n_rst = 1'b1;
    applyStimulus();
    checkOutput("recapture after reset", 32'(data_read), 32'd1);
    checkOutput("recapture data", 32'(r_data), 32'h7E);
    data_ready = 1'b0; overrun_error = 1'b0;
    applyStimulus();

    // Random traffic with phases biased toward filling or draining
    for (int i = 0; i < 1500; i++) begin
      phase = (i / 100) % 2;
      n_rst         = ($urandom_range(0, 199) != 0);
      data_ready    = (phase == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rx_data       = 8'($urandom);
      overrun_error = 1'($urandom_range(0, 1));
      r_enable      = (phase == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) framing_error = ~framing_error;
      clear_errors  = ($urandom_range(0, 49) == 0);
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
